// File: rtl/sv_rr_arbiter.sv
// Round-robin single-owner arbiter: one-hot grant held until done, withdrawal or hold timeout.
// Latency: grant registered one cycle after request; no backpressure, release always idles one cycle.
module sv_rr_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 timeout
);

  localparam int IDW = $clog2(N);
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [IDW-1:0] ID_LAST  = IDW'(N - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   gnt_nx;
  logic [IDW-1:0] gnt_id_nx;
  logic [IDW-1:0] last_id, last_id_nx;
  logic [CW-1:0]  hold_cnt, hold_cnt_nx;
  logic           timeout_nx;
  logic [IDW-1:0] winner, cand;
  logic           found;

  // Search starts just after the last winner so it becomes lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IDW'((int'(last_id) + off) % N);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    gnt_id_nx   = gnt_id;
    last_id_nx  = last_id;
    hold_cnt_nx = hold_cnt;
    timeout_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx        = BUSY;
          gnt_nx          = '0;
          gnt_nx[winner]  = 1'b1;
          gnt_id_nx       = winner;
          last_id_nx      = winner;
          hold_cnt_nx     = '0;
        end
      end
      BUSY: begin
        if (done || !req[gnt_id]) begin
          state_nx    = IDLE;
          gnt_nx      = '0;
          gnt_id_nx   = '0;
          hold_cnt_nx = '0;
        end else if ((TIMEOUT != 0) && (hold_cnt == CNT_LAST)) begin
          state_nx    = IDLE;
          gnt_nx      = '0;
          gnt_id_nx   = '0;
          hold_cnt_nx = '0;
          timeout_nx  = 1'b1;
        end else if (hold_cnt != '1) begin
          hold_cnt_nx = hold_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      last_id  <= ID_LAST;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      gnt_id   <= gnt_id_nx;
      last_id  <= last_id_nx;
      hold_cnt <= hold_cnt_nx;
      timeout  <= timeout_nx;
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: tb/tb_sv_rr_arbiter.sv
// Bench for sv_rr_arbiter: directed scenarios plus randomized traffic checked by a scoreboard.
module tb_sv_rr_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         done = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic         timeout;

  always #5 clk = ~clk;

  sv_rr_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .timeout(timeout)
  );

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [1:0]   id;
    logic         vld;
    logic         to;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: owner index (-1 when idle), last winner, cycles the grant has been visible.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_held  = 0;
  bit m_to    = 1'b0;

  task automatic model_step(input logic [N-1:0] r, input logic d, input logic x);
    if (x) begin
      m_owner = -1; m_last = N - 1; m_held = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && r[c]) begin
          m_owner = c; m_last = c; m_held = 1;
        end
      end
    end else begin
      m_to = 1'b0;
      if (d || !r[m_owner]) m_owner = -1;
      else if (TIMEOUT != 0 && m_held == TIMEOUT) begin
        m_owner = -1; m_to = 1'b1;
      end else m_held++;
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic d, input logic x);
    exp_t e;
    @(negedge clk);
    req = r; done = d; rst = x;
    model_step(r, d, x);
    e.gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    e.id  = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    e.vld = (m_owner >= 0);
    e.to  = m_to;
    expq.push_back(e);
  endtask

  task automatic cycle_s(input logic [N-1:0] r, input logic d, input logic x);
    cycle(r, d, x);
    @(posedge clk);
    #2;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      chk("sb_gnt", 32'(gnt), 32'(mon_e.gnt));
      chk("sb_gnt_id", 32'(gnt_id), 32'(mon_e.id));
      chk("sb_gnt_valid", 32'(gnt_valid), 32'(mon_e.vld));
      chk("sb_timeout", 32'(timeout), 32'(mon_e.to));
      chk("sb_onehot", 32'($onehot0(gnt)), 32'd1);
    end
  end

  initial begin : main
    logic [N-1:0] rot_tbl [13];
    logic [N-1:0] rr;
    int run, to_at, pulses;
    bit released;
    rot_tbl = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};

    // Reset with all requesting, then rotation with done on each grant's second cycle.
    cycle_s(4'b1111, 1'b0, 1'b1);
    cycle_s(4'b1111, 1'b0, 1'b1);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    cycle_s(4'b1111, 1'b0, 1'b0);
    chk("rot_gnt_1", 32'(gnt), 32'(rot_tbl[0]));
    chk("first_id", 32'(gnt_id), 32'd0);
    for (int k = 2; k <= 13; k++) begin
      cycle_s(4'b1111, (k % 3) == 0, 1'b0);
      chk($sformatf("rot_gnt_%0d", k), 32'(gnt), 32'(rot_tbl[k-1]));
    end

    // Priority skip.
    cycle_s(4'b0000, 1'b0, 1'b1);
    cycle_s(4'b0010, 1'b0, 1'b0);
    chk("skip_id1", 32'(gnt_id), 32'd1);
    cycle_s(4'b0010, 1'b1, 1'b0);
    chk("skip_rel", 32'(gnt), 32'd0);
    cycle_s(4'b0001, 1'b0, 1'b0);
    chk("skip_to_0", 32'(gnt), 32'b0001);
    cycle_s(4'b0001, 1'b1, 1'b0);
    cycle_s(4'b0010, 1'b0, 1'b0);
    chk("skip_id1b", 32'(gnt), 32'b0010);
    cycle_s(4'b0010, 1'b1, 1'b0);
    cycle_s(4'b1001, 1'b0, 1'b0);
    chk("skip_to_3", 32'(gnt_id), 32'd3);

    // Timeout: grant held TIMEOUT cycles, one-cycle pulse, then regrant.
    cycle_s(4'b0000, 1'b0, 1'b1);
    run = 0; to_at = 0; pulses = 0; released = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle_s(4'b0100, 1'b0, 1'b0);
      if (gnt == 4'b0100 && !released) run++;
      else released = 1'b1;
      if (timeout) begin to_at = i; pulses++; end
      if (i == 10) chk("to_regrant", 32'(gnt), 32'b0100);
    end
    chk("to_len", 32'(run), 32'(TIMEOUT));
    chk("to_at", 32'(to_at), 32'(TIMEOUT + 1));
    chk("to_pulses", 32'(pulses), 32'd1);

    // done on the last held cycle beats the timeout.
    cycle_s(4'b0000, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) cycle_s(4'b0100, i == 9, 1'b0);
    chk("dvt_gnt", 32'(gnt), 32'd0);
    chk("dvt_timeout", 32'(timeout), 32'd0);

    // Withdraw on third cycle.
    cycle_s(4'b0100, 1'b0, 1'b0);
    cycle_s(4'b0100, 1'b0, 1'b0);
    cycle_s(4'b0000, 1'b0, 1'b0);
    chk("wd_gnt", 32'(gnt), 32'd0);
    chk("wd_timeout", 32'(timeout), 32'd0);

    // Reset mid-grant restores last_id to N-1.
    cycle_s(4'b0100, 1'b0, 1'b0);
    chk("mrst_pre", 32'(gnt), 32'b0100);
    cycle_s(4'b0100, 1'b0, 1'b1);
    chk("mrst_gnt", 32'(gnt), 32'd0);
    cycle_s(4'b0110, 1'b0, 1'b0);
    chk("mrst_id", 32'(gnt_id), 32'd1);

    // Randomized traffic with sticky requests.
    rr = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if (rr[b]) rr[b] = ($urandom_range(7) != 0);
        else       rr[b] = ($urandom_range(3) == 0);
      end
      cycle(rr, $urandom_range(3) == 0, $urandom_range(99) == 0);
    end

    cycle(4'b0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
